// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - start/busy/done handshake bundle for booth_mult_seq (is_signed only with BOOTH_UNSIGNED_EN)
interface booth_mult_seq_if #(
    parameter int W = 5
);
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
`ifdef BOOTH_UNSIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

`ifdef BOOTH_UNSIGNED_EN
    modport master (output start, output a, output b, output is_signed,
                    input busy, input done, input product);
    modport slave  (input start, input a, input b, input is_signed,
                    output busy, output done, output product);
`else
    modport master (output start, output a, output b,
                    input busy, input done, input product);
    modport slave  (input start, input a, input b,
                    output busy, output done, output product);
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, one step per clock; BOOTH_UNSIGNED_EN adds unsigned mode
module booth_mult_seq #(
    parameter int W = 5
) (
    input  logic            clk,
    input  logic            rst,
    booth_mult_seq_if.slave bus
);
`ifdef BOOTH_UNSIGNED_EN
    // one extra multiplier bit so an unsigned operand is scanned with a zero sign
    localparam int QW = W + 1;
`else
    localparam int QW = W;
`endif
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W:0]       m_reg;
    logic [W:0]       p_reg;
    logic [QW-1:0]    q_reg;
    logic             qb;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic [2*W-1:0]   product_r;
`ifdef BOOTH_UNSIGNED_EN
    logic             sgn_reg;
`endif

    logic [W:0]       m_load;
    logic [QW-1:0]    q_load;
    logic [CW-1:0]    n_load;
    logic [W:0]       p_sum;
    logic [W:0]       p_nxt;
    logic [QW-1:0]    q_nxt;
    logic [W+QW:0]    wide_nxt;
    logic [2*W-1:0]   prod_nxt;

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

    // operand extension and iteration count chosen at the accepting edge
    always_comb begin
`ifdef BOOTH_UNSIGNED_EN
        if (bus.is_signed) begin
            m_load = {bus.a[W-1], bus.a};
            q_load = {bus.b[W-1], bus.b};
            n_load = CW'(W);
        end else begin
            m_load = {1'b0, bus.a};
            q_load = {1'b0, bus.b};
            n_load = CW'(W + 1);
        end
`else
        m_load = {bus.a[W-1], bus.a};
        q_load = bus.b;
        n_load = CW'(W);
`endif
    end

    // one Booth step: add/sub on {Q[0], q}, then arithmetic shift of {P, Q, q}
    always_comb begin
        case ({q_reg[0], qb})
            2'b01:   p_sum = p_reg + m_reg;
            2'b10:   p_sum = p_reg - m_reg;
            default: p_sum = p_reg;
        endcase
        p_nxt    = {p_sum[W], p_sum[W:1]};
        q_nxt    = {p_sum[0], q_reg[QW-1:1]};
        wide_nxt = {p_nxt, q_nxt};
`ifdef BOOTH_UNSIGNED_EN
        // signed mode runs W steps, so Q[0] still holds the unscanned top bit
        prod_nxt = sgn_reg ? wide_nxt[2*W:1] : wide_nxt[2*W-1:0];
`else
        prod_nxt = wide_nxt[2*W-1:0];
`endif
    end

    // control FSM and datapath registers; product is written only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_reg     <= '0;
            p_reg     <= '0;
            q_reg     <= '0;
            qb        <= 1'b0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
`ifdef BOOTH_UNSIGNED_EN
            sgn_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        m_reg  <= m_load;
                        p_reg  <= '0;
                        q_reg  <= q_load;
                        qb     <= 1'b0;
                        cnt    <= n_load;
                        busy_r <= 1'b1;
                        state  <= RUN;
`ifdef BOOTH_UNSIGNED_EN
                        sgn_reg <= bus.is_signed;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p_reg <= p_nxt;
                    q_reg <= q_nxt;
                    qb    <= q_reg[0];
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= prod_nxt;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - directed vector bench for booth_mult_seq
module tb_booth_mult_seq;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.W(W)) bus ();
    booth_mult_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sgn;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef BOOTH_UNSIGNED_EN
        bus.is_signed = sgn;
`else
        if (sgn) bus.start = 1'b1;
`endif
    endtask

    function automatic int n_of(input logic sgn);
`ifdef BOOTH_UNSIGNED_EN
        return sgn ? W : W + 1;
`else
        return sgn ? W : W;
`endif
    endfunction

    // called at the negedge right after the accepting edge; returns at the done negedge
    task automatic wait_done(output int k, output int busy_cnt);
        k = 0;
        busy_cnt = 0;
        while (!bus.done && k < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int k, bc;
        drive_op(v.a, v.b, v.sgn);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~v.a;
        bus.b = ~v.b;
        wait_done(k, bc);
        check({name, " done"}, bus.done, 1'b1);
        check({name, " latency"}, k, n_of(v.sgn));
        check({name, " busy cycles"}, bc, n_of(v.sgn));
        check({name, " busy at done"}, bus.busy, 1'b0);
        check({name, " product"}, bus.product, v.exp);
    endtask

    initial begin
        int k, bc, dn;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef BOOTH_UNSIGNED_EN
        bus.is_signed = 1'b1;
`endif
        vecs.push_back('{5'd7,       5'b11101, 1'b1, 10'h3EB});
        vecs.push_back('{5'b10000,   5'b10000, 1'b1, 10'h100});
        vecs.push_back('{5'b10000,   5'd15,    1'b1, 10'h310});
        vecs.push_back('{5'd0,       5'b11001, 1'b1, 10'h000});
        vecs.push_back('{5'b11111,   5'b11111, 1'b1, 10'h001});
        vecs.push_back('{5'd15,      5'd15,    1'b1, 10'h0E1});
        vecs.push_back('{5'b10000,   5'd1,     1'b1, 10'h3F0});
        vecs.push_back('{5'd5,       5'b10000, 1'b1, 10'h3B0});
`ifdef BOOTH_UNSIGNED_EN
        vecs.push_back('{5'd31,      5'd31,    1'b0, 10'h3C1});
        vecs.push_back('{5'd31,      5'd31,    1'b1, 10'h001});
        vecs.push_back('{5'd16,      5'd16,    1'b0, 10'h100});
`endif

        repeat (2) @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset product", bus.product, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", bus.busy, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), bus.done, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d hold", i), bus.product, vecs[i].exp);
        end

        // start during RUN is ignored, then start in DONE is accepted
        drive_op(5'd7, 5'b11101, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive_op(5'b10000, 5'b10000, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        k = 2;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ignore latency", k, W);
        check("ignore product", bus.product, 10'h3EB);
        drive_op(5'b10000, 5'd15, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b done low", bus.done, 1'b0);
        check("b2b busy", bus.busy, 1'b1);
        check("b2b product held", bus.product, 10'h3EB);
        wait_done(k, bc);
        check("b2b latency", k, W);
        check("b2b product", bus.product, 10'h310);
        @(negedge clk);
        check("b2b done pulse", bus.done, 1'b0);

        // reset in the third RUN cycle aborts the operation
        drive_op(5'd7, 5'b11101, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        check("abort product", bus.product, '0);
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort no done", dn, 0);
        check("abort product kept", bus.product, '0);
        run_op("after abort", '{5'd15, 5'd15, 1'b1, 10'h0E1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
